// File: rtl/speed_stats.sv
`default_nettype none
// ============================================================================
// Module   : speed_stats
// Purpose  : Streaming speed statistics. Tracks the peak sample since the
//            last reset/clear and a moving average over the most recent DEPTH
//            samples. The average uses a circular buffer plus a running sum.
//            Each accepted sample adds the new value and subtracts the entry
//            it overwrites, so every sample costs one add and one subtract.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        bit width of speed samples and speed outputs
//   DEPTH        averaging window length; power of two in 2..256
// Ports
//   clk          rising-edge clock
//   r            asynchronous active-low reset
//   speed        unsigned speed sample
//   speed_valid  speed carries a new sample this cycle
//   clear        synchronous statistics clear; wins over speed_valid
//   max_speed    largest sample since reset/clear
//   max_update   one-cycle pulse when max_speed increased
//   avg_speed    mean of the last DEPTH samples (0 until the window is full)
//   avg_valid    window full, avg_speed meaningful
//   min_speed    smallest sample since reset/clear (SPEED_STATS_MIN_EN only)
// Configuration
//   SPEED_STATS_MIN_EN  when defined, adds the min_speed output and register
// ============================================================================
module speed_stats #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] speed,
  input  logic             speed_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] max_speed,
  output logic             max_update,
  output logic [WIDTH-1:0] avg_speed,
  output logic             avg_valid
`ifdef SPEED_STATS_MIN_EN
  ,
  output logic [WIDTH-1:0] min_speed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // A full window of all-ones samples fits exactly in WIDTH+log2(DEPTH) bits,
  // so the running sum can never overflow.
  localparam int SUM_W = WIDTH + PTR_W;
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] sample_buf [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fill_cnt;
  logic [SUM_W-1:0] sum;

  logic             accept;
  logic             window_full;
  logic [WIDTH-1:0] evicted;
  logic [SUM_W-1:0] sum_next;
  logic             max_hit;

  // A clear in the same cycle discards the sample.
  assign accept      = speed_valid & ~clear;
  // Unwritten entries are held at zero, so evicting one during the initial
  // fill subtracts nothing.
  assign evicted     = sample_buf[wr_ptr];
  // The evicted entry is already part of sum, so the subtraction cannot
  // underflow.
  assign sum_next    = sum + SUM_W'(speed) - SUM_W'(evicted);
  assign window_full = (fill_cnt == FILL_FULL);
  assign max_hit     = accept && (speed > max_speed);

  // --------------------------------------------------------------------------
  // Sample buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin
        sample_buf[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        sample_buf[i] <= '0;
      end
    end else if (accept) begin
      sample_buf[wr_ptr] <= speed;
    end
  end

  // --------------------------------------------------------------------------
  // Write pointer, fill counter and running sum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sum      <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sum      <= '0;
    end else if (accept) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (!window_full) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      sum <= sum_next;
    end
  end

  // --------------------------------------------------------------------------
  // Peak tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      max_speed  <= '0;
      max_update <= 1'b0;
    end else if (clear) begin
      max_speed  <= '0;
      max_update <= 1'b0;
    end else begin
      max_update <= max_hit;
      if (max_hit) begin
        max_speed <= speed;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Average output
  // The average is registered from the already-registered sum, so it appears
  // one cycle after the sample edge. It is forced to zero until the window
  // has been filled once. Dropping the low log2(DEPTH) bits of the sum gives
  // the truncating division by DEPTH.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      avg_speed <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      avg_speed <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= window_full;
      avg_speed <= window_full ? sum[SUM_W-1:PTR_W] : '0;
    end
  end

`ifdef SPEED_STATS_MIN_EN
  // --------------------------------------------------------------------------
  // Minimum tracking. The all-ones reset value lets the first sample load
  // unless that sample is itself all-ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      min_speed <= '1;
    end else if (clear) begin
      min_speed <= '1;
    end else if (accept && (speed < min_speed)) begin
      min_speed <= speed;
    end
  end
`endif

endmodule
`default_nettype wire
